// File: rtl/phys_reg_release_queue.sv
// Retire-side release queue: compacts released physical tags from a 4-wide retire bundle into a circular FIFO and drains up to 4 per cycle to the free list.
// Optional RELEASE_DUP_CHECK_EN adds an in-queue tag vector and a sticky dupError_o.
module phys_reg_release_queue #(
    parameter int PHYS_LOG  = 7,
    parameter int DEPTH     = 16,
    parameter int DEPTH_LOG = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 retValid0_i,
    input  logic                 retValid1_i,
    input  logic                 retValid2_i,
    input  logic                 retValid3_i,
    input  logic                 retHasDest0_i,
    input  logic                 retHasDest1_i,
    input  logic                 retHasDest2_i,
    input  logic                 retHasDest3_i,
    input  logic [PHYS_LOG-1:0]  retOldPhys0_i,
    input  logic [PHYS_LOG-1:0]  retOldPhys1_i,
    input  logic [PHYS_LOG-1:0]  retOldPhys2_i,
    input  logic [PHYS_LOG-1:0]  retOldPhys3_i,
    input  logic                 hold_i,
    output logic                 retireStall_o,
    output logic                 commitValid0_o,
    output logic                 commitValid1_o,
    output logic                 commitValid2_o,
    output logic                 commitValid3_o,
    output logic [PHYS_LOG-1:0]  commitReg0_o,
    output logic [PHYS_LOG-1:0]  commitReg1_o,
    output logic [PHYS_LOG-1:0]  commitReg2_o,
    output logic [PHYS_LOG-1:0]  commitReg3_o,
    output logic [DEPTH_LOG:0]   occupancy_o
`ifdef RELEASE_DUP_CHECK_EN
    ,
    output logic                 dupError_o
`endif
);

    localparam int CW = DEPTH_LOG + 1;
    localparam logic [CW-1:0] STALL_ABOVE = CW'(DEPTH - 4);

    logic [DEPTH_LOG-1:0] head;
    logic [DEPTH_LOG-1:0] tail;
    logic [CW-1:0]        count;
    logic [PHYS_LOG-1:0]  mem [DEPTH];

    logic                 ret_valid [4];
    logic                 has_dest  [4];
    logic [PHYS_LOG-1:0]  old_phys  [4];

    logic                 qual      [4];
    logic [DEPTH_LOG-1:0] wr_addr   [4];
    logic [DEPTH_LOG-1:0] rd_addr   [4];
    logic [2:0]           enq;
    logic [2:0]           deq;

    logic                 commit_vld [4];
    logic [PHYS_LOG-1:0]  commit_reg [4];

    assign ret_valid = '{retValid0_i, retValid1_i, retValid2_i, retValid3_i};
    assign has_dest  = '{retHasDest0_i, retHasDest1_i, retHasDest2_i, retHasDest3_i};
    assign old_phys  = '{retOldPhys0_i, retOldPhys1_i, retOldPhys2_i, retOldPhys3_i};

    // Stall looks at occupancy only, so a full-width bundle always fits.
    assign retireStall_o = (count > STALL_ABOVE);
    assign occupancy_o   = count;

    always_comb begin
        enq = 3'd0;
        for (int k = 0; k < 4; k++) begin
            qual[k]    = ret_valid[k] & has_dest[k] & ~retireStall_o;
            wr_addr[k] = tail + DEPTH_LOG'(enq);
            enq        = enq + {2'b00, qual[k]};
        end
    end

    always_comb begin
        if (hold_i)
            deq = 3'd0;
        else if (count >= CW'(4))
            deq = 3'd4;
        else
            deq = count[2:0];
        for (int i = 0; i < 4; i++)
            rd_addr[i] = head + DEPTH_LOG'(i);
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (qual[k])
                mem[wr_addr[k]] <= old_phys[k];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < 4; i++) begin
                commit_vld[i] <= 1'b0;
                commit_reg[i] <= '0;
            end
        end else begin
            head  <= head + DEPTH_LOG'(deq);
            tail  <= tail + DEPTH_LOG'(enq);
            count <= count + CW'(enq) - CW'(deq);
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < deq) begin
                    commit_vld[i] <= 1'b1;
                    commit_reg[i] <= mem[rd_addr[i]];
                end else begin
                    commit_vld[i] <= 1'b0;
                    commit_reg[i] <= '0;
                end
            end
        end
    end

    assign commitValid0_o = commit_vld[0];
    assign commitValid1_o = commit_vld[1];
    assign commitValid2_o = commit_vld[2];
    assign commitValid3_o = commit_vld[3];
    assign commitReg0_o   = commit_reg[0];
    assign commitReg1_o   = commit_reg[1];
    assign commitReg2_o   = commit_reg[2];
    assign commitReg3_o   = commit_reg[3];

`ifdef RELEASE_DUP_CHECK_EN
    logic [2**PHYS_LOG-1:0] in_q;
    logic [2**PHYS_LOG-1:0] in_q_nxt;
    logic                   dup_hit;

    always_comb begin
        in_q_nxt = in_q;
        dup_hit  = 1'b0;
        for (int i = 0; i < 4; i++)
            if (3'(i) < deq)
                in_q_nxt[mem[rd_addr[i]]] = 1'b0;
        // Sets follow clears so a tag leaving and re-entering in one cycle stays marked.
        for (int k = 0; k < 4; k++) begin
            if (qual[k]) begin
                if (in_q[old_phys[k]])
                    dup_hit = 1'b1;
                for (int j = 0; j < k; j++)
                    if (qual[j] && (old_phys[j] == old_phys[k]))
                        dup_hit = 1'b1;
                in_q_nxt[old_phys[k]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_q       <= '0;
            dupError_o <= 1'b0;
        end else begin
            in_q       <= in_q_nxt;
            dupError_o <= dupError_o | dup_hit;
        end
    end
`endif

endmodule

// File: tb/tb_phys_reg_release_queue.sv
// Directed bench for phys_reg_release_queue: a tag-queue model predicts every cycle's outputs; literal checks pin the model.
// Dup-check checks compile in only when RELEASE_DUP_CHECK_EN is defined.
module tb_phys_reg_release_queue;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hold = 1'b0;
    logic [3:0] rv = '0;
    logic [3:0] rh = '0;
    logic [6:0] tag [4];
    logic       stall;
    logic       cv0, cv1, cv2, cv3;
    logic [6:0] cr0, cr1, cr2, cr3;
    logic [4:0] occ;
`ifdef RELEASE_DUP_CHECK_EN
    logic       dup;
`endif

    int checks = 0;
    int errors = 0;

    int  q[$];
    bit  ev [4];
    int  er [4];
    int  eocc = 0;
    bit  estl = 0;
    bit  edup = 0;
    bit  chk_en = 0;

    always #5 clk = ~clk;

    phys_reg_release_queue dut (
        .clk(clk), .reset(reset),
        .retValid0_i(rv[0]), .retValid1_i(rv[1]), .retValid2_i(rv[2]), .retValid3_i(rv[3]),
        .retHasDest0_i(rh[0]), .retHasDest1_i(rh[1]), .retHasDest2_i(rh[2]), .retHasDest3_i(rh[3]),
        .retOldPhys0_i(tag[0]), .retOldPhys1_i(tag[1]), .retOldPhys2_i(tag[2]), .retOldPhys3_i(tag[3]),
        .hold_i(hold), .retireStall_o(stall),
        .commitValid0_o(cv0), .commitValid1_o(cv1), .commitValid2_o(cv2), .commitValid3_o(cv3),
        .commitReg0_o(cr0), .commitReg1_o(cr1), .commitReg2_o(cr2), .commitReg3_o(cr3),
        .occupancy_o(occ)
`ifdef RELEASE_DUP_CHECK_EN
        , .dupError_o(dup)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("vld0", 32'(cv0), 32'(ev[0]));
            chk("vld1", 32'(cv1), 32'(ev[1]));
            chk("vld2", 32'(cv2), 32'(ev[2]));
            chk("vld3", 32'(cv3), 32'(ev[3]));
            chk("reg0", 32'(cr0), 32'(er[0]));
            chk("reg1", 32'(cr1), 32'(er[1]));
            chk("reg2", 32'(cr2), 32'(er[2]));
            chk("reg3", 32'(cr3), 32'(er[3]));
            chk("occupancy", 32'(occ), 32'(eocc));
            chk("stall", 32'(stall), 32'(estl));
`ifdef RELEASE_DUP_CHECK_EN
            chk("dup", 32'(dup), 32'(edup));
`endif
        end
    end

    task automatic step(input logic [3:0] v, input logic [3:0] hd,
                        input int t0, input int t1, input int t2, input int t3,
                        input logic h, input logic rst);
        int tg [4];
        int n;
        bit stl;
        tg = '{t0, t1, t2, t3};
        @(negedge clk);
        reset = rst;
        hold  = h;
        rv    = v;
        rh    = hd;
        for (int k = 0; k < 4; k++) tag[k] = 7'(tg[k]);
        if (rst) begin
            q.delete();
            edup = 0;
            for (int k = 0; k < 4; k++) begin ev[k] = 0; er[k] = 0; end
        end else begin
            stl = (DEPTH - q.size()) < 4;
            if (!stl)
                for (int k = 0; k < 4; k++)
                    if (v[k] && hd[k]) begin
                        foreach (q[i]) if (q[i] == tg[k]) edup = 1;
                        for (int j = 0; j < k; j++)
                            if (v[j] && hd[j] && tg[j] == tg[k]) edup = 1;
                    end
            n = h ? 0 : (q.size() < 4 ? q.size() : 4);
            for (int k = 0; k < 4; k++) begin
                if (k < n) begin ev[k] = 1; er[k] = q.pop_front(); end
                else begin ev[k] = 0; er[k] = 0; end
            end
            if (!stl)
                for (int k = 0; k < 4; k++)
                    if (v[k] && hd[k]) q.push_back(tg[k]);
        end
        eocc = q.size();
        estl = (DEPTH - q.size()) < 4;
        chk_en = 1;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 4'b0000, 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin tag[k] = '0; ev[k] = 0; er[k] = 0; end

        step(4'b0000, 4'b0000, 0, 0, 0, 0, 1'b0, 1'b1);
        step(4'b0000, 4'b0000, 0, 0, 0, 0, 1'b0, 1'b1);
        chk("reset_occ", 32'(occ), 32'd0);
        chk("reset_vld", 32'({cv3, cv2, cv1, cv0}), 32'd0);

        // Full bundle, one idle cycle to drain.
        step(4'b1111, 4'b1111, 5, 6, 7, 8, 1'b0, 1'b0);
        chk("t1_occ_after_enq", 32'(occ), 32'd4);
        idle(1);
        chk("t1_mask", 32'({cv3, cv2, cv1, cv0}), 32'b1111);
        chk("t1_reg0", 32'(cr0), 32'd5);
        chk("t1_reg3", 32'(cr3), 32'd8);
        chk("t1_occ", 32'(occ), 32'd0);
        idle(1);

        // Lanes without a destination are dropped; survivors compact to lane 0.
        step(4'b1111, 4'b1010, 10, 11, 12, 13, 1'b0, 1'b0);
        idle(1);
        chk("t2_mask", 32'({cv3, cv2, cv1, cv0}), 32'b0011);
        chk("t2_reg0", 32'(cr0), 32'd11);
        chk("t2_reg1", 32'(cr1), 32'd13);
        step(4'b0101, 4'b1111, 1, 2, 3, 4, 1'b0, 1'b0);
        idle(2);

        // Hold with 4 tags/cycle: stall from 13 up, later retires ignored.
        for (int c = 0; c < 5; c++) begin
            step(4'b1111, 4'b1111, 40 + 4*c, 41 + 4*c, 42 + 4*c, 43 + 4*c, 1'b1, 1'b0);
            if (c == 2) chk("t3_occ12", 32'(occ), 32'd12);
            if (c == 3) begin
                chk("t3_occ16", 32'(occ), 32'd16);
                chk("t3_stall", 32'(stall), 32'd1);
            end
        end
        chk("t3_occ_held", 32'(occ), 32'd16);
        chk("t3_held_mask", 32'({cv3, cv2, cv1, cv0}), 32'd0);
        idle(1);
        chk("t3_first_reg0", 32'(cr0), 32'd40);
        chk("t3_first_reg3", 32'(cr3), 32'd43);
        idle(5);
        chk("t3_empty", 32'(occ), 32'd0);

        // Wrap: move head/tail to 14, then 20..23 span 14,15,0,1.
        step(4'b0000, 4'b0000, 0, 0, 0, 0, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++)
            step(4'b1111, 4'b1111, 70 + 4*c, 71 + 4*c, 72 + 4*c, 73 + 4*c, 1'b1, 1'b0);
        step(4'b0011, 4'b0011, 90, 91, 0, 0, 1'b1, 1'b0);
        chk("t4_occ14", 32'(occ), 32'd14);
        idle(5);
        step(4'b1111, 4'b1111, 20, 21, 22, 23, 1'b0, 1'b0);
        idle(1);
        chk("t4_reg0", 32'(cr0), 32'd20);
        chk("t4_reg1", 32'(cr1), 32'd21);
        chk("t4_reg2", 32'(cr2), 32'd22);
        chk("t4_reg3", 32'(cr3), 32'd23);
        idle(1);

        // Reset with 9 queued discards everything.
        step(4'b1111, 4'b1111, 50, 51, 52, 53, 1'b1, 1'b0);
        step(4'b1111, 4'b1111, 54, 55, 56, 57, 1'b1, 1'b0);
        step(4'b0001, 4'b0001, 58, 0, 0, 0, 1'b1, 1'b0);
        chk("t5_occ9", 32'(occ), 32'd9);
        step(4'b1111, 4'b1111, 1, 2, 3, 4, 1'b1, 1'b1);
        chk("t5_occ0", 32'(occ), 32'd0);
        chk("t5_mask", 32'({cv3, cv2, cv1, cv0}), 32'd0);
        step(4'b1111, 4'b1111, 60, 61, 62, 63, 1'b0, 1'b0);
        idle(1);
        chk("t5_reg0", 32'(cr0), 32'd60);
        idle(1);

`ifdef RELEASE_DUP_CHECK_EN
        step(4'b0001, 4'b0001, 33, 0, 0, 0, 1'b1, 1'b0);
        chk("dup_clear", 32'(dup), 32'd0);
        step(4'b0001, 4'b0001, 33, 0, 0, 0, 1'b1, 1'b0);
        chk("dup_set", 32'(dup), 32'd1);
        idle(3);
        chk("dup_sticky", 32'(dup), 32'd1);
        step(4'b0000, 4'b0000, 0, 0, 0, 0, 1'b0, 1'b1);
        chk("dup_reset", 32'(dup), 32'd0);
        step(4'b0101, 4'b0101, 9, 0, 9, 0, 1'b0, 1'b0);
        chk("dup_bundle", 32'(dup), 32'd1);
        idle(1);
`endif

        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
